// File: rtl/ffe_tap_sequencer_if.sv
// Purpose: valid/ready sample path, coefficient write port and status signals of the
//          time-multiplexed FFE tap sequencer.
// Signals:
//   in_valid/in_ready/in_sample       upstream sample handshake
//   coef_wr_en/addr/data, coef_wr_err coefficient bank write port and drop indication
//   out_valid/out_ready/out_data      downstream equalized-sample handshake
//   mux_sel, busy                     tap select and MAC-in-progress status
// Modports: slave = sequencer side, master = source/sink side.
interface ffe_tap_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned COEF_WIDTH = 12
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_sample;
    logic                         coef_wr_en;
    logic [1:0]                   coef_wr_addr;
    logic signed [COEF_WIDTH-1:0] coef_wr_data;
    logic                         coef_wr_err;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic [1:0]                   mux_sel;
    logic                         busy;

    modport slave (
        input  in_valid, in_sample, coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
        output in_ready, coef_wr_err, out_valid, out_data, mux_sel, busy
    );

    modport master (
        output in_valid, in_sample, coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
        input  in_ready, coef_wr_err, out_valid, out_data, mux_sel, busy
    );
endinterface

// File: rtl/ffe_tap_sequencer.sv
// Purpose: 4-tap FFE controller; one shared signed MAC is time-multiplexed over a
//          4-entry sample delay line and coefficient bank, one tap per cycle.
// Ports:
//   CLK   rising-edge clock
//   RST   asynchronous active-low reset
//   bus   ffe_tap_sequencer_if.slave (sample in, coef write, result out, status)
// Timing: accept edge -> 4 MAC edges -> out_valid; result held until out_ready.
module ffe_tap_sequencer #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned COEF_WIDTH = 12,
    parameter int unsigned FRAC_BITS  = 10,
    parameter int unsigned ACC_WIDTH  = 26
) (
    input  logic                  CLK,
    input  logic                  RST,
    ffe_tap_sequencer_if.slave    bus
);
    localparam int unsigned NUM_TAPS   = 4;
    localparam int unsigned PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  x_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]  x_d [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]  c_q [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]  c_d [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [1:0]                    mux_sel_q, mux_sel_d;
    logic                          out_valid_q, out_valid_d;
    logic                          coef_wr_err_q, coef_wr_err_d;

    logic                          in_ready_c;
    logic signed [PROD_WIDTH-1:0]  prod_c;
    logic signed [ACC_WIDTH-1:0]   acc_sum_c;
    logic signed [ACC_WIDTH-1:0]   shifted_c;
    logic signed [DATA_WIDTH-1:0]  sat_c;

    // Sample acceptance: idle, or draining the held result on this same edge.
    assign in_ready_c = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);

    // Shared datapath: one tap product, running sum, scaling and clamp.
    always_comb begin
        prod_c    = PROD_WIDTH'(x_q[mux_sel_q]) * PROD_WIDTH'(c_q[mux_sel_q]);
        acc_sum_c = acc_q + ACC_WIDTH'(prod_c);
        shifted_c = acc_sum_c >>> FRAC_BITS;
        if (shifted_c > SAT_MAX) begin
            sat_c = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted_c < SAT_MIN) begin
            sat_c = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_c = shifted_c[DATA_WIDTH-1:0];
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        c_d           = c_q;
        acc_d         = acc_q;
        out_data_d    = out_data_q;
        mux_sel_d     = mux_sel_q;
        out_valid_d   = out_valid_q;
        coef_wr_err_d = 1'b0;

        // Coefficient bank only writable while idle; otherwise flag the drop.
        if (bus.coef_wr_en) begin
            if (state_q == ST_IDLE) begin
                c_d[bus.coef_wr_addr] = bus.coef_wr_data;
            end else begin
                coef_wr_err_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: ;
            ST_MAC: begin
                acc_d     = acc_sum_c;
                mux_sel_d = mux_sel_q + 2'd1;
                if (mux_sel_q == 2'd3) begin
                    out_data_d  = sat_c;
                    out_valid_d = 1'b1;
                    mux_sel_d   = 2'd0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept shifts the FIR history and starts a fresh accumulation.
        if (bus.in_valid && in_ready_c) begin
            x_d[3]    = x_q[2];
            x_d[2]    = x_q[1];
            x_d[1]    = x_q[0];
            x_d[0]    = bus.in_sample;
            acc_d     = '0;
            mux_sel_d = 2'd0;
            state_d   = ST_MAC;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < NUM_TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
            acc_q         <= '0;
            out_data_q    <= '0;
            mux_sel_q     <= 2'd0;
            out_valid_q   <= 1'b0;
            coef_wr_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            c_q           <= c_d;
            acc_q         <= acc_d;
            out_data_q    <= out_data_d;
            mux_sel_q     <= mux_sel_d;
            out_valid_q   <= out_valid_d;
            coef_wr_err_q <= coef_wr_err_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.mux_sel     = mux_sel_q;
    assign bus.busy        = (state_q == ST_MAC);
    assign bus.coef_wr_err = coef_wr_err_q;
endmodule
